// File: rtl/rv32_irq_ctrl.sv
// Per-hart machine interrupt controller: shared prescaled mtime, per-hart mtimecmp/msip,
// edge-latched external interrupts, and a registered irq request/cause per hart.
module rv32_irq_ctrl #(
  parameter int NUM_HARTS  = 8,
  parameter int XPR_LEN    = 32,
  parameter int TIME_WIDTH = 64,
  parameter int PRESCALE   = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [XPR_LEN-1:0]             wdata,
  output logic [XPR_LEN-1:0]             rdata,
  output logic                           rvalid,
  output logic                           err,
  input  logic [NUM_HARTS-1:0]           irq_ext,
  input  logic [NUM_HARTS*XPR_LEN-1:0]   mie,
  input  logic [NUM_HARTS-1:0]           mstatus_mie,
  input  logic [NUM_HARTS-1:0]           irq_ack,
  output logic [NUM_HARTS*XPR_LEN-1:0]   mip,
  output logic [NUM_HARTS-1:0]           irq_valid,
  output logic [NUM_HARTS*XPR_LEN-1:0]   irq_cause
);

  localparam int NW = TIME_WIDTH / XPR_LEN;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]          presc;
  logic                   tick;
  logic                   wr;
  logic [TIME_WIDTH-1:0]  mtime;
  logic [TIME_WIDTH-1:0]  mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0]   msip;
  logic [NUM_HARTS-1:0]   meip;
  logic [NUM_HARTS-1:0]   mtip;
  logic [NUM_HARTS-1:0]   irq_ext_q;

  logic [31:0]            a;
  logic                   mapped;
  logic [XPR_LEN-1:0]     rd_val;
  logic [NW-1:0]          hit_time;
  logic [NUM_HARTS-1:0]   hit_msip;
  logic [NW-1:0]          hit_cmp [NUM_HARTS];

  logic [XPR_LEN-1:0]     pend;
  logic [NUM_HARTS-1:0]   pend_any;
  logic [NUM_HARTS-1:0]   ack_clr;
  logic [3:0]             code [NUM_HARTS];

  assign tick = (presc == PW'(PRESCALE - 1));
  assign wr   = req & we;

  // Register port: a req sampled at posedge is answered by a one-cycle rvalid
  // strobe on the next cycle (err alongside it when the address is unmapped).
  always_comb begin
    a        = 32'(addr) & 32'hFFFF_FFFC;
    mapped   = 1'b0;
    rd_val   = '0;
    hit_time = '0;
    hit_msip = '0;
    hit_cmp  = '{default: '0};
    for (int w = 0; w < NW; w++) begin
      if (a == 32'(4 * w)) begin
        hit_time[w] = 1'b1;
        mapped      = 1'b1;
        rd_val      = mtime[w*XPR_LEN +: XPR_LEN];
      end
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (a == 32'(256 + 4 * h)) begin
        hit_msip[h] = 1'b1;
        mapped      = 1'b1;
        rd_val      = {{(XPR_LEN-1){1'b0}}, msip[h]};
      end
      for (int w = 0; w < NW; w++) begin
        if (a == 32'(512 + 8 * h + 4 * w)) begin
          hit_cmp[h][w] = 1'b1;
          mapped        = 1'b1;
          rd_val        = mtimecmp[h][w*XPR_LEN +: XPR_LEN];
        end
      end
    end
  end

  always_comb begin
    mip      = '0;
    pend     = '0;
    pend_any = '0;
    ack_clr  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mip[h*XPR_LEN + 11] = meip[h];
      mip[h*XPR_LEN + 7]  = mtip[h];
      mip[h*XPR_LEN + 3]  = msip[h];
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      pend        = mip[h*XPR_LEN +: XPR_LEN] & mie[h*XPR_LEN +: XPR_LEN];
      pend_any[h] = |pend;
      // Priority MEI > MSI > MTI
      if (pend[11])     code[h] = 4'd11;
      else if (pend[3]) code[h] = 4'd3;
      else              code[h] = 4'd7;
      ack_clr[h] = irq_ack[h] & irq_valid[h] & (irq_cause[h*XPR_LEN +: 4] == 4'd11);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      mtime     <= '0;
      msip      <= '0;
      meip      <= '0;
      mtip      <= '0;
      irq_ext_q <= '0;
      irq_valid <= '0;
      irq_cause <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      // A software write to any mtime word suppresses that cycle's tick entirely
      if (wr && (|hit_time)) begin
        for (int w = 0; w < NW; w++)
          if (hit_time[w]) mtime[w*XPR_LEN +: XPR_LEN] <= wdata;
      end else if (tick) begin
        mtime <= mtime + 1'b1;
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && hit_msip[h]) msip[h] <= wdata[0];
        for (int w = 0; w < NW; w++)
          if (wr && hit_cmp[h][w]) mtimecmp[h][w*XPR_LEN +: XPR_LEN] <= wdata;
        mtip[h]      <= (mtime >= mtimecmp[h]);
        irq_valid[h] <= mstatus_mie[h] & pend_any[h];
        if (mstatus_mie[h] && pend_any[h])
          irq_cause[h*XPR_LEN +: XPR_LEN] <= {1'b1, {(XPR_LEN-5){1'b0}}, code[h]};
      end
      // A new rising edge outranks an acknowledge in the same cycle
      irq_ext_q <= irq_ext;
      meip      <= (irq_ext & ~irq_ext_q) | (meip & ~ack_clr);
      rvalid    <= req;
      err       <= req & ~mapped;
      rdata     <= (req && !we) ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_rv32_irq_ctrl.sv
// Directed bench for rv32_irq_ctrl: register-map vector table plus hand-timed
// sequences for the timer, external-interrupt acknowledge and reset corners.
module tb_rv32_irq_ctrl;

  localparam int NH = 8;
  localparam int XL = 32;

  logic              clk;
  logic              rst;
  logic              req;
  logic              we;
  logic [11:0]       addr;
  logic [XL-1:0]     wdata;
  logic [XL-1:0]     rdata;
  logic              rvalid;
  logic              err;
  logic [NH-1:0]     irq_ext;
  logic [NH*XL-1:0]  mie;
  logic [NH-1:0]     mstatus_mie;
  logic [NH-1:0]     irq_ack;
  logic [NH*XL-1:0]  mip;
  logic [NH-1:0]     irq_valid;
  logic [NH*XL-1:0]  irq_cause;

  int checks = 0;
  int errors = 0;

  rv32_irq_ctrl #(.NUM_HARTS(NH), .XPR_LEN(XL), .TIME_WIDTH(64), .PRESCALE(1), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .err(err), .irq_ext(irq_ext), .mie(mie),
    .mstatus_mie(mstatus_mie), .irq_ack(irq_ack), .mip(mip),
    .irq_valid(irq_valid), .irq_cause(irq_cause)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one request and samples the response one cycle later.
  task automatic bus_chk(input string nm, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk({nm, " rvalid"}, {31'b0, rvalid}, 32'd1);
    chk({nm, " rdata"}, rdata, exp_rd);
    chk({nm, " err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [23];

  initial begin
    vecs[0]  = '{1'b0, 12'h000, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 12'h200, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1'b0, 12'h204, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{1'b0, 12'h23C, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{1'b0, 12'h100, 32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b1, 12'h104, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 12'h104, 32'h0,        32'h1,        1'b0};
    vecs[7]  = '{1'b1, 12'h104, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{1'b0, 12'h106, 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{1'b0, 12'h120, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 12'h7FC, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 12'h120, 32'h1,        32'h0,        1'b1};
    vecs[12] = '{1'b1, 12'h7FC, 32'h5,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 12'h240, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 12'h240, 32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b1, 12'h208, 32'h12345678, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 12'h208, 32'h0,        32'h12345678, 1'b0};
    vecs[17] = '{1'b1, 12'h20C, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[18] = '{1'b0, 12'h20C, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[19] = '{1'b1, 12'h208, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[20] = '{1'b1, 12'h20C, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[21] = '{1'b0, 12'h23C, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[22] = '{1'b0, 12'h008, 32'h0,        32'h0,        1'b1};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    irq_ext = '0; mie = '0; mstatus_mie = '0; irq_ack = '0;
    repeat (3) @(negedge clk);
    chk("reset rvalid", {31'b0, rvalid}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset irq_valid", {24'b0, irq_valid}, 32'd0);
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("reset mip[%0d]", h), mip[h*XL +: XL], 32'd0);
      chk($sformatf("reset cause[%0d]", h), irq_cause[h*XL +: XL], 32'd0);
    end

    // register map table; first row is issued on the cycle reset drops
    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      bus_chk($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_err);
      chk($sformatf("vec%0d irq_valid", i), {24'b0, irq_valid}, 32'd0);
    end
    @(negedge clk);
    chk("idle rvalid", {31'b0, rvalid}, 32'd0);

    // mtime: write beats tick, other half holds, all-ones wraps to zero
    bus_chk("mt wr lo", 1'b1, 12'h000, 32'h00001000, 32'h0, 1'b0);
    bus_chk("mt rd lo", 1'b0, 12'h000, 32'h0, 32'h00001000, 1'b0);
    bus_chk("mt wr lo1", 1'b1, 12'h000, 32'hFFFFFFFF, 32'h0, 1'b0);
    bus_chk("mt wr hi1", 1'b1, 12'h004, 32'hFFFFFFFF, 32'h0, 1'b0);
    bus_chk("mt hold lo", 1'b0, 12'h000, 32'h0, 32'hFFFFFFFF, 1'b0);
    bus_chk("mt wrap lo", 1'b0, 12'h000, 32'h0, 32'h0, 1'b0);
    bus_chk("mt wrap hi", 1'b0, 12'h004, 32'h0, 32'h0, 1'b0);

    // timer interrupt on hart 2: mtime = n at the negedge after edge n
    bus_chk("tm hi0", 1'b1, 12'h004, 32'h0, 32'h0, 1'b0);
    bus_chk("tm lo0", 1'b1, 12'h000, 32'h0, 32'h0, 1'b0);
    mie[2*XL +: XL] = 32'h80;
    mstatus_mie[2] = 1'b1;
    bus_chk("tm cmp lo", 1'b1, 12'h210, 32'd20, 32'h0, 1'b0);
    bus_chk("tm cmp hi", 1'b1, 12'h214, 32'd0, 32'h0, 1'b0);
    for (int n = 3; n <= 25; n++) begin
      @(negedge clk);
      chk($sformatf("tm mtip n=%0d", n), {31'b0, mip[2*XL + 7]}, {31'b0, (n >= 21)});
      chk($sformatf("tm valid n=%0d", n), {24'b0, irq_valid}, (n >= 22) ? 32'h04 : 32'h00);
      if (n >= 22) chk($sformatf("tm cause n=%0d", n), irq_cause[2*XL +: XL], 32'h80000007);
    end
    mie[2*XL +: XL] = '0;
    mstatus_mie[2] = 1'b0;
    bus_chk("tm cmp lo r", 1'b1, 12'h210, 32'hFFFFFFFF, 32'h0, 1'b0);
    bus_chk("tm cmp hi r", 1'b1, 12'h214, 32'hFFFFFFFF, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("tm off valid", {24'b0, irq_valid}, 32'd0);
    chk("tm off mip2", mip[2*XL +: XL], 32'd0);

    // hart 0: msip + pulsed external interrupt, acknowledge ordering
    mie[0 +: XL] = 32'h808;
    mstatus_mie[0] = 1'b1;
    bus_chk("ext msip", 1'b1, 12'h100, 32'h1, 32'h0, 1'b0);
    chk("ext mip sw", mip[0 +: XL], 32'h008);
    @(negedge clk);
    chk("ext valid sw", {24'b0, irq_valid}, 32'h01);
    chk("ext cause sw", irq_cause[0 +: XL], 32'h80000003);
    irq_ext[0] = 1'b1;
    @(negedge clk);
    irq_ext[0] = 1'b0;
    chk("ext mip both", mip[0 +: XL], 32'h808);
    @(negedge clk);
    chk("ext cause mei", irq_cause[0 +: XL], 32'h8000000B);
    irq_ack[0] = 1'b1;
    @(negedge clk);
    irq_ack[0] = 1'b0;
    chk("ack mip", mip[0 +: XL], 32'h008);
    chk("ack cause hold", irq_cause[0 +: XL], 32'h8000000B);
    @(negedge clk);
    chk("ack cause msi", irq_cause[0 +: XL], 32'h80000003);
    chk("ack valid", {24'b0, irq_valid}, 32'h01);
    irq_ack[0] = 1'b1;
    @(negedge clk);
    irq_ack[0] = 1'b0;
    chk("ack3 mip", mip[0 +: XL], 32'h008);
    @(negedge clk);
    chk("ack3 cause", irq_cause[0 +: XL], 32'h80000003);
    bus_chk("ext msip clr", 1'b1, 12'h100, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ext valid drop", {24'b0, irq_valid}, 32'h00);
    chk("ext cause keep", irq_cause[0 +: XL], 32'h80000003);
    mie[0 +: XL] = '0;
    mstatus_mie[0] = 1'b0;

    // hart 1: level held high latches once; ack while high does not re-set
    mie[1*XL +: XL] = 32'h800;
    mstatus_mie[1] = 1'b1;
    irq_ext[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      irq_ack[1] = (c == 1 || c == 3);
      @(negedge clk);
      chk($sformatf("lvl meip c=%0d", c), {31'b0, mip[1*XL + 11]}, {31'b0, (c <= 2)});
      chk($sformatf("lvl valid c=%0d", c), {24'b0, irq_valid}, (c == 2 || c == 3) ? 32'h02 : 32'h00);
      if (c == 2) chk("lvl cause", irq_cause[1*XL +: XL], 32'h8000000B);
    end
    irq_ack[1] = 1'b0;
    irq_ext[1] = 1'b0;
    @(negedge clk);
    chk("lvl low meip", {31'b0, mip[1*XL + 11]}, 32'd0);
    irq_ext[1] = 1'b1;
    @(negedge clk);
    chk("lvl re-edge meip", {31'b0, mip[1*XL + 11]}, 32'd1);
    irq_ext[1] = 1'b0;
    mstatus_mie[1] = 1'b0;
    mie[1*XL +: XL] = '0;

    // reset arriving with a request in flight
    bus_chk("pre rst cmp", 1'b1, 12'h208, 32'h5, 32'h0, 1'b0);
    req = 1'b1; we = 1'b0; addr = 12'h208; rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("rst drop rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst mip1", mip[1*XL +: XL], 32'd0);
    chk("rst cause0", irq_cause[0 +: XL], 32'd0);
    rst = 1'b0;
    bus_chk("post rst cmp", 1'b0, 12'h208, 32'h0, 32'hFFFFFFFF, 1'b0);
    bus_chk("post rst mtime", 1'b0, 12'h000, 32'h0, 32'h1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_irq_ctrl.md
Name: rv32_irq_ctrl

Overview:
Parametrised per-hart machine interrupt controller for the pito barrel core: shared 64-bit mtime, per-hart mtimecmp, msip and latched external interrupts.
Produces per-hart mip words (mip_rv32_t layout), a gated interrupt request and an exception_t-format cause to the CSR/trap logic.
Generalises the fixed single-hart mip/mie definitions to NUM_HARTS channels with a memory-mapped register port on the data-memory side.

Parameters:
NUM_HARTS, 8, number of hart channels (1..32)
XPR_LEN, 32, register/data width
TIME_WIDTH, 64, mtime/mtimecmp width (multiple of XPR_LEN, 32 or 64)
PRESCALE, 1, clk cycles per mtime tick (>=1)
ADDR_WIDTH, 12, register port byte-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  register access request
we  in  1  1=write, 0=read
addr  in  ADDR_WIDTH  byte address, word aligned (addr[1:0] ignored)
wdata  in  XPR_LEN  write data
rdata  out  XPR_LEN  read data, valid when rvalid
rvalid  out  1  read/write response strobe
err  out  1  unmapped-address strobe, same cycle as rvalid
irq_ext  in  NUM_HARTS  level external interrupt per hart
mie  in  NUM_HARTS*XPR_LEN  per-hart mie CSR (mie_rv32_t)
mstatus_mie  in  NUM_HARTS  per-hart global enable
irq_ack  in  NUM_HARTS  trap taken for hart h (1-cycle pulse)
mip  out  NUM_HARTS*XPR_LEN  per-hart mip (meip bit 11, mtip bit 7, msip bit 3, all other bits 0)
irq_valid  out  NUM_HARTS  per-hart interrupt request
irq_cause  out  NUM_HARTS*XPR_LEN  per-hart cause: {1'b1, 27'b0, code}

Behaviour:
- Single clock clk; reset synchronous, active-high on rst; every register updates on rising clk only.
- Reset: mtime=0, prescaler=0, every mtimecmp=all-ones, msip=0, meip latch=0, mip=0, irq_valid=0, irq_cause=0, rdata=0, rvalid=0, err=0.
- Register map: 0x000 mtime[31:0]; 0x004 mtime[63:32] (TIME_WIDTH=64 only); 0x100+4h msip[h] (bit0 only, rest read 0); 0x200+8h mtimecmp[h] lo, +4 hi. h>=NUM_HARTS or any other address = unmapped.
- Access: req sampled at posedge; rvalid=1 exactly next cycle for every req (reads and writes); rdata holds read value (0 for writes and unmapped); err=1 with rvalid for unmapped; unmapped write has no effect. Back-to-back req every cycle supported.
- mtime: prescaler counts 0..PRESCALE-1; on wrap mtime+=1, modulo 2^TIME_WIDTH (all-ones wraps to 0). Software write to a mtime half in the same cycle as a tick: write wins for written half; other half holds (no carry that cycle).
- mtip[h] = (mtime >= mtimecmp[h]) unsigned, registered: visible in mip one cycle after the mtime/mtimecmp update. Halves are written non-atomically.
- meip[h]: set on rising edge of irq_ext[h] (edge detect register, reset 0); cleared by irq_ack[h] when irq_cause[h] code=11; set and clear same cycle -> set wins.
- msip[h]: software only; not cleared by ack.
- Per hart: pend = mip & mie; irq_valid[h] = mstatus_mie[h] & |pend, registered (1 cycle after mip). Code priority MEI(11) > MSI(3) > MTI(7); irq_cause updated same cycle as irq_valid, holds last value when irq_valid=0.
- irq_ack with irq_valid=0 or cause!=11: no state change.
- Reset asserted mid-access: pending response dropped, rvalid=0 next cycle.

Test Plan:
- Reset, then read 0x000, 0x200, 0x204 -> rdata 0, 0xFFFFFFFF, 0xFFFFFFFF, rvalid one cycle after each req, err=0; irq_valid=0.
- PRESCALE=1, write mtimecmp[2]=20 (lo) and 0 (hi), mie[2] bit7=1, mstatus_mie[2]=1 -> mip[2] bit7 rises the cycle after mtime reaches 20, irq_valid[2] one cycle later, cause 0x80000007; other harts idle.
- Pulse irq_ext[0] 1 cycle with mie bit11 and msip[0]=1, mie bit3 set -> cause 0x8000000B; irq_ack[0] -> meip cleared, cause becomes 0x80000003 two cycles later.
- Hold irq_ext[1] high 10 cycles, ack after first cycle -> meip set only once, no re-set while level stays high.
- Write mtime lo=0xFFFFFFFF, hi=0xFFFFFFFF -> after one tick mtime reads 0x00000000/0x00000000; write to mtime on tick cycle keeps written value.
- Read 0x100+4*NUM_HARTS and 0x7FC -> rdata 0, err=1; write there -> no register changes.
